// File: rtl/reg_rename_file.sv
// reg_rename_file
// Architectural register file with rename tags. Each of the 32 registers
// has a 32-bit committed value and a 4-bit ROB tag. A nonzero tag means the
// value is still being produced by that ROB entry. x0 always reads 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable; state held while low
//   in_decode_rs1/rs2        read indices (combinational read)
//   out_decode_value1/2      stored value of rs1/rs2
//   out_decode_tag1/2        pending ROB tag of rs1/rs2 (0 = value valid)
//   in_decode_ce/rd/rob_tag  rename request: tag[rd] <= rob_tag
//   in_rob_index/tag/value   commit from ROB (index 0 = no commit)
//   in_misbranch             flush: clear every tag, drop this cycle's rename
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a read of the register being committed
//                      this cycle (with a matching tag) returns the commit
//                      value and tag 0 instead of the stored state.

module reg_rename_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [4:0]  in_decode_rs1,
  input  logic [4:0]  in_decode_rs2,
  output logic [31:0] out_decode_value1,
  output logic [31:0] out_decode_value2,
  output logic [3:0]  out_decode_tag1,
  output logic [3:0]  out_decode_tag2,
  input  logic        in_decode_ce,
  input  logic [4:0]  in_decode_rd,
  input  logic [3:0]  in_decode_rob_tag,
  input  logic [4:0]  in_rob_index,
  input  logic [3:0]  in_rob_tag,
  input  logic [31:0] in_rob_value,
  input  logic        in_misbranch
);

  logic [31:0][31:0] value_q;
  logic [31:0][3:0]  tag_q;

  logic commit_en;
  logic rename_en;

  assign commit_en = rdy && (in_rob_index != 5'd0);
  assign rename_en = rdy && in_decode_ce && (in_decode_rd != 5'd0) && !in_misbranch;

  // Later assignments take priority: a flush clears everything after the
  // commit's conditional clear, and a rename to the committing register
  // overrides that clear so the newer producer is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      tag_q   <= '0;
    end else begin
      if (commit_en) begin
        value_q[in_rob_index] <= in_rob_value;
        if (tag_q[in_rob_index] == in_rob_tag) begin
          tag_q[in_rob_index] <= 4'd0;
        end
      end
      if (rdy && in_misbranch) begin
        tag_q <= '0;
      end else if (rename_en) begin
        tag_q[in_decode_rd] <= in_decode_rob_tag;
      end
    end
  end

  // Reads see the state before this cycle's rename, so an instruction that
  // reads and writes the same register picks up the older producer.
  always_comb begin
    out_decode_value1 = value_q[in_decode_rs1];
    out_decode_tag1   = tag_q[in_decode_rs1];
    out_decode_value2 = value_q[in_decode_rs2];
    out_decode_tag2   = tag_q[in_decode_rs2];
`ifdef REGFILE_BYPASS_EN
    if ((in_rob_index != 5'd0) && (in_decode_rs1 == in_rob_index) &&
        (tag_q[in_decode_rs1] == in_rob_tag)) begin
      out_decode_value1 = in_rob_value;
      out_decode_tag1   = 4'd0;
    end
    if ((in_rob_index != 5'd0) && (in_decode_rs2 == in_rob_index) &&
        (tag_q[in_decode_rs2] == in_rob_tag)) begin
      out_decode_value2 = in_rob_value;
      out_decode_tag2   = 4'd0;
    end
`endif
    // Entry 0 is never written; force zero so x0 is independent of storage.
    if (in_decode_rs1 == 5'd0) begin
      out_decode_value1 = 32'd0;
      out_decode_tag1   = 4'd0;
    end
    if (in_decode_rs2 == 5'd0) begin
      out_decode_value2 = 32'd0;
      out_decode_tag2   = 4'd0;
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Testbench for reg_rename_file: directed scenarios plus randomized traffic
// checked against an array-based reference model.

module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  in_decode_rs1, in_decode_rs2;
  logic [31:0] out_decode_value1, out_decode_value2;
  logic [3:0]  out_decode_tag1, out_decode_tag2;
  logic        in_decode_ce;
  logic [4:0]  in_decode_rd;
  logic [3:0]  in_decode_rob_tag;
  logic [4:0]  in_rob_index;
  logic [3:0]  in_rob_tag;
  logic [31:0] in_rob_value;
  logic        in_misbranch;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_val [32];
  logic [3:0]  m_tag [32];

  always #5 clk = ~clk;

  reg_rename_file dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_decode_rs1(in_decode_rs1), .in_decode_rs2(in_decode_rs2),
    .out_decode_value1(out_decode_value1), .out_decode_value2(out_decode_value2),
    .out_decode_tag1(out_decode_tag1), .out_decode_tag2(out_decode_tag2),
    .in_decode_ce(in_decode_ce), .in_decode_rd(in_decode_rd),
    .in_decode_rob_tag(in_decode_rob_tag),
    .in_rob_index(in_rob_index), .in_rob_tag(in_rob_tag),
    .in_rob_value(in_rob_value), .in_misbranch(in_misbranch)
  );

  function automatic logic [31:0] exp_val(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (rs == in_rob_index && m_tag[rs] == in_rob_tag) return in_rob_value;
`endif
    return m_val[rs];
  endfunction

  function automatic logic [3:0] exp_tag(input logic [4:0] rs);
    if (rs == 5'd0) return 4'd0;
`ifdef REGFILE_BYPASS_EN
    if (rs == in_rob_index && m_tag[rs] == in_rob_tag) return 4'd0;
`endif
    return m_tag[rs];
  endfunction

  // Advance one clock and apply the architectural rules to the model.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'd0;
        m_tag[i] = 4'd0;
      end
    end else if (rdy) begin
      if (in_rob_index != 5'd0) begin
        m_val[in_rob_index] = in_rob_value;
        if (m_tag[in_rob_index] == in_rob_tag) m_tag[in_rob_index] = 4'd0;
      end
      if (in_misbranch) begin
        for (int i = 0; i < 32; i++) m_tag[i] = 4'd0;
      end else if (in_decode_ce && in_decode_rd != 5'd0) begin
        m_tag[in_decode_rd] = in_decode_rob_tag;
      end
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1;
    in_decode_rs1 = 5'd0; in_decode_rs2 = 5'd0;
    in_decode_ce = 1'b0; in_decode_rd = 5'd0; in_decode_rob_tag = 4'd0;
    in_rob_index = 5'd0; in_rob_tag = 4'd0; in_rob_value = 32'd0;
    in_misbranch = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
    idle();
    in_decode_ce = 1'b1; in_decode_rd = rd; in_decode_rob_tag = tag;
    step();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step(); step();
    idle(); in_decode_rs1 = 5'd5; in_decode_rs2 = 5'd0; #1;
    checks++; if (out_decode_value1 !== 32'd0) begin errors++; $display("FAIL reset_value1 got %h exp 0", out_decode_value1); end
    checks++; if (out_decode_tag1 !== 4'd0) begin errors++; $display("FAIL reset_tag1 got %h exp 0", out_decode_tag1); end
    checks++; if (out_decode_value2 !== 32'd0) begin errors++; $display("FAIL reset_value2 got %h exp 0", out_decode_value2); end
    checks++; if (out_decode_tag2 !== 4'd0) begin errors++; $display("FAIL reset_tag2 got %h exp 0", out_decode_tag2); end
  endtask

  task automatic test_rename_commit();
    idle(); in_decode_rs1 = 5'd3; in_decode_ce = 1'b1; in_decode_rd = 5'd3; in_decode_rob_tag = 4'd7; #1;
    checks++; if (out_decode_tag1 !== 4'd0) begin errors++; $display("FAIL rename_read_old got %h exp 0", out_decode_tag1); end
    step();
    idle(); in_decode_rs1 = 5'd3; #1;
    checks++; if (out_decode_tag1 !== 4'd7) begin errors++; $display("FAIL rename_tag got %h exp 7", out_decode_tag1); end
    in_rob_index = 5'd3; in_rob_tag = 4'd7; in_rob_value = 32'h1234;
    step();
    idle(); in_decode_rs1 = 5'd3; #1;
    checks++; if (out_decode_tag1 !== 4'd0) begin errors++; $display("FAIL commit_tag got %h exp 0", out_decode_tag1); end
    checks++; if (out_decode_value1 !== 32'h1234) begin errors++; $display("FAIL commit_value got %h exp 1234", out_decode_value1); end
  endtask

  task automatic test_stale_commit();
    rename(5'd4, 4'd2);
    rename(5'd4, 4'd5);
    idle(); in_rob_index = 5'd4; in_rob_tag = 4'd2; in_rob_value = 32'hAA;
    step();
    idle(); in_decode_rs2 = 5'd4; #1;
    checks++; if (out_decode_value2 !== 32'hAA) begin errors++; $display("FAIL stale_value got %h exp aa", out_decode_value2); end
    checks++; if (out_decode_tag2 !== 4'd5) begin errors++; $display("FAIL stale_tag got %h exp 5", out_decode_tag2); end
  endtask

  task automatic test_same_cycle();
    rename(5'd6, 4'd3);
    idle(); in_decode_ce = 1'b1; in_decode_rd = 5'd6; in_decode_rob_tag = 4'd9;
    in_rob_index = 5'd6; in_rob_tag = 4'd3; in_rob_value = 32'h55;
    step();
    idle(); in_decode_rs1 = 5'd6; #1;
    checks++; if (out_decode_value1 !== 32'h55) begin errors++; $display("FAIL same_cycle_value got %h exp 55", out_decode_value1); end
    checks++; if (out_decode_tag1 !== 4'd9) begin errors++; $display("FAIL same_cycle_tag got %h exp 9", out_decode_tag1); end
  endtask

  task automatic test_misbranch();
    rename(5'd1, 4'd4);
    rename(5'd2, 4'd8);
    rename(5'd31, 4'd12);
    idle(); in_misbranch = 1'b1; in_rob_index = 5'd1; in_rob_tag = 4'd4; in_rob_value = 32'h10;
    in_decode_ce = 1'b1; in_decode_rd = 5'd5; in_decode_rob_tag = 4'd3;
    step();
    idle(); in_decode_rs1 = 5'd1; in_decode_rs2 = 5'd2; #1;
    checks++; if (out_decode_value1 !== 32'h10) begin errors++; $display("FAIL flush_x1_value got %h exp 10", out_decode_value1); end
    checks++; if (out_decode_tag1 !== 4'd0) begin errors++; $display("FAIL flush_x1_tag got %h exp 0", out_decode_tag1); end
    checks++; if (out_decode_tag2 !== 4'd0) begin errors++; $display("FAIL flush_x2_tag got %h exp 0", out_decode_tag2); end
    in_decode_rs1 = 5'd31; in_decode_rs2 = 5'd5; #1;
    checks++; if (out_decode_tag1 !== 4'd0) begin errors++; $display("FAIL flush_x31_tag got %h exp 0", out_decode_tag1); end
    checks++; if (out_decode_tag2 !== 4'd0) begin errors++; $display("FAIL flush_rename_dropped got %h exp 0", out_decode_tag2); end
  endtask

  task automatic test_bypass();
    rename(5'd8, 4'd6);
    idle(); in_rob_index = 5'd8; in_rob_tag = 4'd6; in_rob_value = 32'hBEEF; in_decode_rs2 = 5'd8; #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (out_decode_value2 !== 32'hBEEF) begin errors++; $display("FAIL bypass_value got %h exp beef", out_decode_value2); end
    checks++; if (out_decode_tag2 !== 4'd0) begin errors++; $display("FAIL bypass_tag got %h exp 0", out_decode_tag2); end
`else
    checks++; if (out_decode_tag2 !== 4'd6) begin errors++; $display("FAIL no_bypass_tag got %h exp 6", out_decode_tag2); end
    checks++; if (out_decode_value2 !== 32'd0) begin errors++; $display("FAIL no_bypass_value got %h exp 0", out_decode_value2); end
`endif
    step();
  endtask

  task automatic test_rdy_low();
    rename(5'd12, 4'd13);
    idle(); rdy = 1'b0; in_misbranch = 1'b1;
    in_decode_ce = 1'b1; in_decode_rd = 5'd10; in_decode_rob_tag = 4'd11;
    in_rob_index = 5'd3; in_rob_tag = 4'd0; in_rob_value = 32'hDEAD;
    step(); step();
    idle(); in_decode_rs1 = 5'd12; in_decode_rs2 = 5'd10; #1;
    checks++; if (out_decode_tag1 !== 4'd13) begin errors++; $display("FAIL rdy_low_tag_kept got %h exp d", out_decode_tag1); end
    checks++; if (out_decode_tag2 !== 4'd0) begin errors++; $display("FAIL rdy_low_no_rename got %h exp 0", out_decode_tag2); end
    in_decode_rs1 = 5'd3; #1;
    checks++; if (out_decode_value1 !== 32'h1234) begin errors++; $display("FAIL rdy_low_no_commit got %h exp 1234", out_decode_value1); end
  endtask

  task automatic test_random();
    logic [4:0] idx;
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy = ($urandom_range(9, 0) != 0);
      in_decode_ce = $urandom_range(1, 0) != 0;
      in_decode_rd = 5'($urandom_range(31, 0));
      in_decode_rob_tag = 4'($urandom_range(15, 1));
      idx = ($urandom_range(1, 0) != 0) ? 5'($urandom_range(31, 0)) : 5'd0;
      in_rob_index = idx;
      in_rob_tag = ($urandom_range(1, 0) != 0) ? m_tag[idx] : 4'($urandom_range(15, 1));
      in_rob_value = $urandom;
      in_misbranch = ($urandom_range(15, 0) == 0);
      in_decode_rs1 = ($urandom_range(3, 0) == 0) ? idx : 5'($urandom_range(31, 0));
      in_decode_rs2 = 5'($urandom_range(31, 0));
      #1;
      checks++; if (out_decode_value1 !== exp_val(in_decode_rs1)) begin errors++; $display("FAIL rand_value1 n=%0d got %h exp %h", n, out_decode_value1, exp_val(in_decode_rs1)); end
      checks++; if (out_decode_tag1 !== exp_tag(in_decode_rs1)) begin errors++; $display("FAIL rand_tag1 n=%0d got %h exp %h", n, out_decode_tag1, exp_tag(in_decode_rs1)); end
      checks++; if (out_decode_value2 !== exp_val(in_decode_rs2)) begin errors++; $display("FAIL rand_value2 n=%0d got %h exp %h", n, out_decode_value2, exp_val(in_decode_rs2)); end
      checks++; if (out_decode_tag2 !== exp_tag(in_decode_rs2)) begin errors++; $display("FAIL rand_tag2 n=%0d got %h exp %h", n, out_decode_tag2, exp_tag(in_decode_rs2)); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    idle(); rst = 1'b1; rdy = 1'b0;
    in_decode_ce = 1'b1; in_decode_rd = 5'd9; in_decode_rob_tag = 4'd1;
    in_rob_index = 5'd9; in_rob_value = 32'hFFFF_FFFF;
    step();
    idle();
    for (int i = 0; i < 32; i++) begin
      in_decode_rs1 = 5'(i); in_decode_rs2 = 5'(31 - i); #1;
      checks++; if (out_decode_value1 !== 32'd0 || out_decode_tag1 !== 4'd0) begin errors++; $display("FAIL mid_reset_rs1 x%0d got %h/%h exp 0/0", i, out_decode_value1, out_decode_tag1); end
      checks++; if (out_decode_value2 !== 32'd0 || out_decode_tag2 !== 4'd0) begin errors++; $display("FAIL mid_reset_rs2 x%0d got %h/%h exp 0/0", 31 - i, out_decode_value2, out_decode_tag2); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_misbranch();
    test_bypass();
    test_rdy_low();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
